instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage_pkg.sv | 17 +
 rtl/instr_fetch_stage_mem.sv | 25 ++
 rtl/instr_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared CPU definitions for the instruction fetch stage: default sizing,
// the NOP encoding and the fetch FSM state encoding.
package instr_fetch_stage_pkg;

    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_mem.sv
// Instruction memory: DEPTH x 32 words, synchronous write, asynchronous read.
// Contents are never reset so a loaded program survives a reset pulse.
module instr_mem #(
    parameter int DEPTH = instr_fetch_stage_pkg::DEFAULT_DEPTH,
    parameter int AW    = instr_fetch_stage_pkg::DEFAULT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: loads a program into instr_mem, then streams it
// into the IF/ID register honouring stall and branch redirects.
module instr_fetch_stage #(
    parameter int DEPTH = instr_fetch_stage_pkg::DEFAULT_DEPTH,
    parameter int AW    = instr_fetch_stage_pkg::DEFAULT_AW
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          LoadInstructions,
    input  logic [31:0]   Instruction,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic [31:0]   if_id_instr,
    output logic [AW-1:0] if_id_pc,
    output logic          if_id_valid,
    output logic [AW:0]   prog_len,
    output logic          load_full,
    output logic          running
);

    import instr_fetch_stage_pkg::*;

    fetch_state_t  state;
    fetch_state_t  state_next;
    // pc carries one extra bit so it can sit at prog_len == DEPTH without wrapping
    logic [AW:0]   pc;
    logic [AW:0]   pc_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic [AW:0]   len_next;
    logic [31:0]   instr_next;
    logic [AW-1:0] id_pc_next;
    logic          valid_next;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_rdata;

    instr_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(Instruction),
        .raddr(pc[AW-1:0]),
        .rdata(mem_rdata)
    );

    assign load_full = (prog_len == (AW+1)'(DEPTH));
    assign running   = (state == RUN);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc          <= '0;
            wr_ptr      <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            wr_ptr      <= wr_ptr_next;
            if_id_instr <= instr_next;
            if_id_pc    <= id_pc_next;
            if_id_valid <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        prog_len <= len_next;
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        wr_ptr_next = wr_ptr;
        len_next    = prog_len;
        instr_next  = if_id_instr;
        id_pc_next  = if_id_pc;
        valid_next  = if_id_valid;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr;

        // A load request outside LOAD always starts a fresh program at address 0
        if (LoadInstructions && (state != LOAD)) begin
            state_next  = LOAD;
            mem_we      = 1'b1;
            mem_waddr   = '0;
            wr_ptr_next = AW'(1);
            len_next    = (AW+1)'(1);
            pc_next     = '0;
            instr_next  = NOP_INSTR;
            valid_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc_next    = '0;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    if (prog_len != '0) begin
                        state_next = RUN;
                    end
                end
                LOAD: begin
                    pc_next    = '0;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    if (!LoadInstructions) begin
                        state_next = IDLE;
                    end else if (!load_full) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + 1'b1;
                        len_next    = prog_len + 1'b1;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_next    = {1'b0, branch_target};
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                        if ({1'b0, branch_target} >= prog_len) begin
                            state_next = DONE;
                        end
                    end else if (!stall) begin
                        if (pc >= prog_len) begin
                            state_next = DONE;
                            instr_next = NOP_INSTR;
                            valid_next = 1'b0;
                        end else begin
                            instr_next = mem_rdata;
                            id_pc_next = pc[AW-1:0];
                            valid_next = 1'b1;
                            pc_next    = pc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed load/run/stall/branch
// table plus hand-written reset, end-of-program and overflow sequences.
module tb_instr_fetch_stage;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          Reset;
    logic          LoadInstructions;
    logic [31:0]   Instruction;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [31:0]   if_id_instr;
    logic [AW-1:0] if_id_pc;
    logic          if_id_valid;
    logic [AW:0]   prog_len;
    logic          load_full;
    logic          running;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog [40];

    typedef struct packed {
        logic          load;
        logic [31:0]   instr;
        logic          stl;
        logic          br;
        logic [AW-1:0] target;
        logic          exp_valid;
        logic [31:0]   exp_instr;
        logic          chk_pc;
        logic [AW-1:0] exp_pc;
        logic          exp_running;
    } vec_t;

    vec_t vecs [14];

    instr_fetch_stage #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .LoadInstructions(LoadInstructions),
        .Instruction     (Instruction),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .prog_len        (prog_len),
        .load_full       (load_full),
        .running         (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic load, input logic [31:0] instr, input logic stl,
                                 input logic br, input logic [AW-1:0] tgt);
        LoadInstructions = load;
        Instruction      = instr;
        stall            = stl;
        branch_taken     = br;
        branch_target    = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadProgram(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, prog[i], 1'b0, 1'b0, '0);
        end
        LoadInstructions = 1'b0;
        Instruction      = '0;
    endtask

    task automatic checkFetch(input string tag, input logic [AW-1:0] exp_pc, input logic [31:0] exp_instr);
        checkOutput($sformatf("%s.valid", tag), 64'(if_id_valid), 64'(1'b1));
        checkOutput($sformatf("%s.pc", tag), 64'(if_id_pc), 64'(exp_pc));
        checkOutput($sformatf("%s.instr", tag), 64'(if_id_instr), 64'(exp_instr));
    endtask

    task automatic checkBubble(input string tag, input logic exp_running);
        checkOutput($sformatf("%s.valid", tag), 64'(if_id_valid), 64'(1'b0));
        checkOutput($sformatf("%s.instr", tag), 64'(if_id_instr), 64'(32'h0));
        checkOutput($sformatf("%s.running", tag), 64'(running), 64'(exp_running));
    endtask

    initial begin
        // Ten-word program 0x1000_0000 + i: load, stall, branch-with-stall, branch, run off the end
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 5'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 5'd0, 1'b1};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0000, 1'b1, 5'd0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h1000_0000, 1'b1, 5'd0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h1000_0000, 1'b1, 5'd0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0001, 1'b1, 5'd1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0002, 1'b1, 5'd2, 1'b1};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0,         1'b0, 5'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0004, 1'b1, 5'd4, 1'b1};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0005, 1'b1, 5'd5, 1'b1};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0,         1'b0, 5'd0, 1'b1};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1000_0009, 1'b1, 5'd9, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 5'd0, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 5'd0, 1'b0};

        Reset            = 1'b1;
        LoadInstructions = 1'b0;
        Instruction      = '0;
        stall            = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = '0;
        prog[0] = {6'd0, 5'd20, 5'd22, 5'd12, 5'd0, 6'h20};
        prog[1] = {6'd0, 5'd2,  5'd3,  5'd1,  5'd0, 6'h20};
        prog[2] = {6'd0, 5'd1,  5'd8,  5'd5,  5'd0, 6'h20};

        #1 Reset = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst.valid", 64'(if_id_valid), 64'(1'b0));
        checkOutput("rst.instr", 64'(if_id_instr), 64'(32'h0));
        checkOutput("rst.pc", 64'(if_id_pc), 64'(5'd0));
        checkOutput("rst.running", 64'(running), 64'(1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 Reset = 1'b1;

        $display("[TB] three-word program across a reset pulse");
        loadProgram(3);
        Reset = 1'b0;
        #1;
        checkOutput("A.prog_len", 64'(prog_len), 64'(6'd3));
        checkOutput("A.rst_running", 64'(running), 64'(1'b0));
        #1 Reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkBubble("A.enter_run", 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
            checkFetch($sformatf("A.fetch%0d", k), AW'(k), prog[k]);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkBubble("A.done", 1'b0);

        $display("[TB] table: stall, branch under stall, end of program");
        for (int i = 0; i < 40; i++) begin
            prog[i] = 32'h1000_0000 + 32'(i);
        end
        loadProgram(10);
        checkOutput("B.prog_len", 64'(prog_len), 64'(6'd10));
        checkOutput("B.load_full", 64'(load_full), 64'(1'b0));
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].load, vecs[v].instr, vecs[v].stl, vecs[v].br, vecs[v].target);
            checkOutput($sformatf("vec%0d.valid", v), 64'(if_id_valid), 64'(vecs[v].exp_valid));
            checkOutput($sformatf("vec%0d.instr", v), 64'(if_id_instr), 64'(vecs[v].exp_instr));
            checkOutput($sformatf("vec%0d.running", v), 64'(running), 64'(vecs[v].exp_running));
            if (vecs[v].chk_pc) begin
                checkOutput($sformatf("vec%0d.pc", v), 64'(if_id_pc), 64'(vecs[v].exp_pc));
            end
        end

        $display("[TB] asynchronous reset mid-run");
        Reset = 1'b0;
        #1 Reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("D.enter_run", 64'(running), 64'(1'b1));
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        end
        checkFetch("D.at_pc5", 5'd5, prog[5]);
        Reset = 1'b0;
        #1;
        checkOutput("D.async.valid", 64'(if_id_valid), 64'(1'b0));
        checkOutput("D.async.instr", 64'(if_id_instr), 64'(32'h0));
        checkOutput("D.async.pc", 64'(if_id_pc), 64'(5'd0));
        checkOutput("D.async.running", 64'(running), 64'(1'b0));
        #2 Reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("D.rerun", 64'(running), 64'(1'b1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkFetch("D.restart", 5'd0, prog[0]);

        $display("[TB] branch to prog_len");
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd10);
        checkBubble("E.branch", 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkBubble("E.done1", 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkBubble("E.done2", 1'b0);

        $display("[TB] overflow load of 40 words");
        loadProgram(40);
        checkOutput("F.prog_len", 64'(prog_len), 64'(6'd32));
        checkOutput("F.load_full", 64'(load_full), 64'(1'b1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("F.idle", 64'(running), 64'(1'b0));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("F.run", 64'(running), 64'(1'b1));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd31);
        checkBubble("F.branch31", 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkFetch("F.word31", 5'd31, prog[31]);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkBubble("F.no_wrap", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
